// File: rtl/ps2_pkg.sv
`default_nettype none
// ps2_pkg: PS/2 receive FSM encoding, frame constants and the parity helper
// used by the receiver and its byte FIFO.
package ps2_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// ps2_byte_fifo: first-word-fall-through byte FIFO; a pop frees room for a
// push in the same cycle, and a pop is ignored while empty.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [DATA_BITS-1:0]   data_i,
  input  logic                   pop_i,
  output logic [DATA_BITS-1:0]   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ps2_rx_fifo: PS/2 device-to-host frame receiver with glitch-filtered clock,
// frame timeout, error pulses and a byte FIFO with sticky overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2Clk,
  input  logic                   ps2Dat,
  input  logic                   rdEn,
  input  logic                   clrOverflow,
  output logic [DATA_BITS-1:0]   dataOut,
  output logic                   notEmpty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parityErr,
  output logic                   frameErr,
  output logic                   overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]           clk_sync_q, dat_sync_q;
  logic                 clk_lvl_q;
  logic [FW-1:0]        filt_cnt_q;
  logic                 clk_s, dat_s, bit_edge;
  ps2_state_e           state_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [TW-1:0]        to_cnt_q;
  logic                 parity_err_q, frame_err_q, overflow_q;
  logic                 push, fifo_full, fifo_empty;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_lvl_q  <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2Clk};
      dat_sync_q <= {dat_sync_q[0], ps2Dat};
      if (clk_s != clk_lvl_q) begin
        if (filt_cnt_q == FILT_LAST) begin
          clk_lvl_q  <= clk_s;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  // Edge fires in the cycle the filtered level is about to fall, so latency is fixed.
  assign bit_edge = clk_lvl_q && !clk_s && (filt_cnt_q == FILT_LAST);
  assign push     = (state_q == ST_STOP) && bit_edge && dat_s && odd_parity_ok(shift_q, par_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q == ST_IDLE || bit_edge) to_cnt_q <= '0;
      else if (to_cnt_q != TO_LAST)       to_cnt_q <= to_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: if (bit_edge && !dat_s) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= '0;
        end
        ST_DATA: if (bit_edge) begin
          shift_q   <= {dat_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_q <= ST_PARITY;
        end
        ST_PARITY: if (bit_edge) begin
          par_q   <= dat_s;
          state_q <= ST_STOP;
        end
        ST_STOP: if (bit_edge) begin
          state_q <= ST_IDLE;
          if (!dat_s)                              frame_err_q  <= 1'b1;
          else if (!odd_parity_ok(shift_q, par_q)) parity_err_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (state_q != ST_IDLE && !bit_edge && to_cnt_q == TO_LAST) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  overflow_q <= 1'b0;
    else if (push && fifo_full && !(rdEn && !fifo_empty)) overflow_q <= 1'b1;
    else if (clrOverflow)                       overflow_q <= 1'b0;
  end

  ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (rdEn),
    .data_o  (dataOut),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign notEmpty  = !fifo_empty;
  assign parityErr = parity_err_q;
  assign frameErr  = frame_err_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// tb_ps2_rx_fifo: randomized PS/2 frames against a queue-based model; monitors
// pop received bytes and error pulses and compare them with the scoreboard.
module tb_ps2_rx_fifo;

  localparam int DEPTH       = 4;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 10;

  logic clk = 1'b0, reset = 1'b0, ps2Clk = 1'b1, ps2Dat = 1'b1, rdEn = 1'b0, clrOverflow = 1'b0;
  logic [7:0] dataOut;
  logic       notEmpty, parityErr, frameErr, overflow;
  logic [$clog2(DEPTH):0] count;

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  int         err_q[$];          // 1 = parity error, 2 = frame error
  bit         rd_enable = 1'b1;
  bit         exp_ovf   = 1'b0;
  logic [7:0] exp_b;
  int         got_err, want_err;

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat), .rdEn(rdEn),
    .clrOverflow(clrOverflow), .dataOut(dataOut), .notEmpty(notEmpty), .count(count),
    .parityErr(parityErr), .frameErr(frameErr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Dat = bits[i];
      wait_cyc(HALF);
      ps2Clk = 1'b0;
      wait_cyc(HALF);
      ps2Clk = 1'b1;
    end
    ps2Dat = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad parity and bad stop
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par, stop;
    par  = ~^b;
    stop = 1'b1;
    if (kind == 1 || kind == 3) par = ~par;
    if (kind >= 2) stop = 1'b0;
    if (kind == 0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      err_q.push_back(kind == 1 ? 1 : 2);
    end
    send_bits({stop, par, b, 1'b0}, 11);
    wait_cyc(2 * HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, " dataOut"},   32'(dataOut),   32'h0);
    check({tag, " notEmpty"},  32'(notEmpty),  32'h0);
    check({tag, " count"},     32'(count),     32'h0);
    check({tag, " parityErr"}, 32'(parityErr), 32'h0);
    check({tag, " frameErr"},  32'(frameErr),  32'h0);
    check({tag, " overflow"},  32'(overflow),  32'h0);
  endtask

  // Byte monitor: pops whenever the FIFO presents a byte and the reader is on.
  initial forever begin
    @(negedge clk);
    if (!reset && rd_enable && notEmpty) begin
      if (exp_q.size() == 0) begin
        check("unexpected byte", 32'(dataOut), 32'hFFFF_FFFF);
      end else begin
        exp_b = exp_q.pop_front();
        check("rx byte", 32'(dataOut), 32'(exp_b));
      end
      rdEn = 1'b1;
    end else begin
      rdEn = 1'b0;
    end
  end

  // Error monitor: every high cycle of a pulse is one event.
  initial forever begin
    @(negedge clk);
    if (parityErr || frameErr) begin
      got_err = frameErr ? 2 : 1;
      if (parityErr && frameErr) check("both error pulses", 32'd3, 32'(got_err));
      else if (err_q.size() == 0) check("unexpected error pulse", 32'(got_err), 32'd0);
      else begin
        want_err = err_q.pop_front();
        check("error kind", 32'(got_err), 32'(want_err));
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    wait_cyc(5);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_cyc(20);

    // Byte held in the FIFO while the reader is off.
    rd_enable = 1'b0;
    send_frame(8'h1C, 0);
    @(negedge clk);
    check("1C count", 32'(count), 32'd1);
    check("1C notEmpty", 32'(notEmpty), 32'd1);
    check("1C dataOut", 32'(dataOut), 32'h1C);
    rd_enable = 1'b1;
    wait_cyc(5);
    check("1C drained", 32'(count), 32'd0);

    send_frame(8'h1C, 1);
    check("bad parity count", 32'(count), 32'd0);

    for (int i = 0; i < 30; i++) begin
      int k;
      k = int'($urandom_range(0, 5));
      send_frame(8'($urandom), (k < 3) ? 0 : k - 2);
      if ($urandom_range(0, 2) == 0) begin
        ps2Clk = 1'b0;
        wait_cyc(int'($urandom_range(1, FILTER_LEN - 1)));
        ps2Clk = 1'b1;
        wait_cyc(20);
      end
    end

    // Truncated frame: start plus three data bits, then silence.
    err_q.push_back(2);
    send_bits(11'b000_0000_0110, 4);
    wait_cyc(TIMEOUT_CYC + 50);
    check("timeout pulse seen", 32'(err_q.size()), 32'd0);
    send_frame(8'hF0, 0);

    // Fill past capacity with no reads.
    rd_enable = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    @(negedge clk);
    check("full count", 32'(count), 32'(DEPTH));
    check("overflow set", 32'(overflow), 32'(exp_ovf));
    rd_enable = 1'b1;
    wait_cyc(20);
    check("drained count", 32'(count), 32'd0);
    check("overflow sticky", 32'(overflow), 32'(exp_ovf));

    // Reset mid-frame.
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
    reset = 1'b1;
    exp_ovf = 1'b0;
    wait_cyc(3);
    check_reset_outputs("midframe reset");
    reset = 1'b0;
    wait_cyc(20);
    send_frame(8'h5A, 0);

    // Overflow then clear.
    rd_enable = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 0);
    @(negedge clk);
    check("overflow again", 32'(overflow), 32'(exp_ovf));
    clrOverflow = 1'b1;
    wait_cyc(1);
    clrOverflow = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check("overflow cleared", 32'(overflow), 32'(exp_ovf));
    rd_enable = 1'b1;

    for (int i = 0; i < 200 && (exp_q.size() != 0 || err_q.size() != 0); i++) wait_cyc(1);
    check("bytes outstanding", 32'(exp_q.size()), 32'd0);
    check("errors outstanding", 32'(err_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; power of two, at least 2.
REQ-002 SHALL have parameter FILTER_LEN, default 4, number of consecutive equal clk samples needed to accept a ps2Clk level change.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles without a ps2Clk falling edge before an in-progress frame is aborted.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as follows.
REQ-005 clk  input  1  system clock; all state is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ps2Clk  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-008 ps2Dat  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-009 rdEn  input  1  pop request; ignored when the FIFO is empty.
REQ-010 clrOverflow  input  1  clears overflow.
REQ-011 dataOut  output  8  FIFO head byte, first-word-fall-through; valid while notEmpty=1.
REQ-012 notEmpty  output  1  FIFO holds at least one byte.
REQ-013 count  output  $clog2(DEPTH)+1  number of bytes stored.
REQ-014 parityErr  output  1  one-cycle pulse when a frame is discarded for bad parity.
REQ-015 frameErr  output  1  one-cycle pulse when a frame is discarded for a bad stop bit or a timeout.
REQ-016 overflow  output  1  sticky flag; a valid byte was dropped because the FIFO was full.

Function
REQ-017 SHALL pass ps2Clk and ps2Dat each through a 2-flop synchroniser.
REQ-018 SHALL change the filtered clock level only after FILTER_LEN consecutive synchronised samples that differ from the current level.
REQ-019 SHALL treat each 1->0 transition of the filtered clock as a bit edge, and sample synchronised ps2Dat in that cycle.
REQ-020 Bit-edge latency from the raw pin SHALL be 2+FILTER_LEN clk cycles, and constant.
REQ-021 FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: edge with data=0 -> DATA, bit counter=0; edge with data=1 -> stay in IDLE, no error.
REQ-022 DATA SHALL shift bits in LSB first; on the 8th edge -> PARITY.
REQ-023 PARITY SHALL store the bit and go to STOP on the next edge.
REQ-024 STOP edge SHALL return to IDLE and act on the frame as follows.
- Stop=1 and odd parity over data+parity: push the byte.
- Stop=1 and parity bad: pulse parityErr, discard.
- Stop=0: pulse frameErr, discard; frameErr takes precedence over parityErr.
REQ-025 Outside IDLE, a counter SHALL reset on every edge; at TIMEOUT_CYC cycles it SHALL pulse frameErr and force IDLE.
REQ-026 The timeout counter SHALL saturate and stay cleared while in IDLE.
REQ-027 A push SHALL occur in the cycle of the STOP edge; notEmpty and count SHALL update in the following cycle.
REQ-028 A pop SHALL occur on rdEn=1 while notEmpty=1; dataOut SHALL show the next byte in the following cycle.
REQ-029 Push while full, without a pop: drop the byte, set overflow, leave the FIFO unchanged.
REQ-030 Push and pop in the same cycle while full: both SHALL succeed, count unchanged, overflow not set.
REQ-031 Push and pop in the same cycle while empty: only the push takes effect.
REQ-032 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-033 clrOverflow SHALL clear overflow; a new overflow event in the same cycle wins.
REQ-034 Reset values: dataOut=0, notEmpty=0, count=0, parityErr=0, frameErr=0, overflow=0.

Reset
REQ-035 Reset SHALL asynchronously clear synchronisers, filter, FSM (to IDLE), counters, pointers and flags.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; the next complete frame after deassertion SHALL be received normally.

Structure
REQ-037 Package ps2_pkg SHALL hold the FSM state encoding and constants: DATA_BITS=8, FRAME_BITS=11.
REQ-038 Storage SHALL be one sub-module, ps2_byte_fifo, parameterised by DEPTH, with push/pop/full/empty/count ports.

Verification
REQ-039 Frame 0x1C (parity 0, stop 1) -> after STOP, notEmpty=1, count=1, dataOut=0x1C, no error pulses.
REQ-040 Frame 0x1C with parity 1 -> parityErr high exactly one cycle, count stays 0.
REQ-041 DEPTH=4, frames 0x01..0x05, no reads -> count=4, overflow=1; four pops return 0x01, 0x02, 0x03, 0x04.
REQ-042 Start bit plus 3 data bits, then clock idle for TIMEOUT_CYC -> one frameErr pulse; the following frame 0xF0 (parity 1) is received as 0xF0.
REQ-043 FILTER_LEN=4, 2-cycle low glitch on ps2Clk while idle -> no state change, no pulses.
REQ-044 Reset after 5 bits of a frame -> all outputs 0; the next frame 0x5A (parity 1) is received as 0x5A.
